// File: rtl/joystick_sampler_if.sv
// ADC command/response handshake bundle between the joystick sampler (master)
// and the ADC front end (slave).
interface joystick_sampler_if;
  logic        cmd_valid;
  logic [4:0]  cmd_channel;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [4:0]  rsp_channel;
  logic [11:0] rsp_data;

  modport master (
    output cmd_valid,
    output cmd_channel,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_channel,
    input  rsp_data
  );

  modport slave (
    input  cmd_valid,
    input  cmd_channel,
    output cmd_ready,
    output rsp_valid,
    output rsp_channel,
    output rsp_data
  );
endinterface

// File: rtl/joystick_sampler.sv
// Per-frame joystick sampler: averages 2^AVG_LOG2 ADC samples per axis (Y then X)
// and thresholds the averages with hysteresis into movement flags.
module joystick_sampler #(
  parameter int unsigned AVG_LOG2  = 2,
  parameter int unsigned HI_THRESH = 2000,
  parameter int unsigned LO_THRESH = 700,
  parameter int unsigned HYST      = 100,
  parameter int unsigned CH_Y      = 1,
  parameter int unsigned CH_X      = 2,
  parameter int unsigned TIMEOUT   = 4095
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                new_frame_i,
  joystick_sampler_if.master  adc_if,
  output logic [11:0]         y_avg_o,
  output logic [11:0]         x_avg_o,
  output logic                move_fwd_o,
  output logic                move_back_o,
  output logic                turn_left_o,
  output logic                turn_right_o,
  output logic                dir_valid_o,
  output logic                sample_err_o
);

  localparam int unsigned AccW = 12 + AVG_LOG2;
  localparam int unsigned CntW = AVG_LOG2 + 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam logic [4:0]      ChY   = 5'(CH_Y);
  localparam logic [4:0]      ChX   = 5'(CH_X);
  localparam logic [CntW-1:0] NSamp = CntW'(1 << AVG_LOG2);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StReqY, StWaitY, StReqX, StWaitX, StDone} state_e;

  state_e          state_q, state_d;
  logic [AccW-1:0] acc_q, acc_d, ysum_q, ysum_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            err_q, err_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic [4:0]      chan_q, chan_d;
  logic [11:0]     y_avg_q, x_avg_q;
  logic            fwd_q, back_q, left_q, right_q, dir_valid_q;
  logic [4:0]      cur_ch;
  logic            rsp_hit;
  logic [11:0]     y_new, x_new;

  function automatic logic hi_flag(input logic [11:0] a, input logic prev);
    if (32'(a) > HI_THRESH) return 1'b1;
    if (32'(a) < HI_THRESH - HYST) return 1'b0;
    return prev;
  endfunction

  function automatic logic lo_flag(input logic [11:0] a, input logic prev);
    if (32'(a) < LO_THRESH) return 1'b1;
    if (32'(a) > LO_THRESH + HYST) return 1'b0;
    return prev;
  endfunction

  assign cur_ch  = (state_q == StWaitX) ? ChX : ChY;
  assign rsp_hit = adc_if.rsp_valid && (adc_if.rsp_channel == cur_ch);
  assign y_new   = ysum_q[AccW-1:AVG_LOG2];
  assign x_new   = acc_q[AccW-1:AVG_LOG2];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ysum_d  = ysum_q;
    cnt_d   = cnt_q;
    tmo_d   = '0;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (new_frame_i) begin
          state_d = StReqY;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      StReqY: if (cmd_valid_q && adc_if.cmd_ready) state_d = StWaitY;
      StReqX: if (cmd_valid_q && adc_if.cmd_ready) state_d = StWaitX;
      StWaitY, StWaitX: begin
        if (rsp_hit) begin
          acc_d = acc_q + AccW'(adc_if.rsp_data);
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == NSamp) begin
            if (state_q == StWaitY) begin
              // Park the Y sum so the accumulator can be reused for X.
              ysum_d  = acc_d;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = StReqX;
            end else begin
              state_d = StDone;
            end
          end else begin
            state_d = (state_q == StWaitY) ? StReqY : StReqX;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_d == TmoMax) begin
            state_d = StIdle;
            err_d   = 1'b1;
            tmo_d   = '0;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        err_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase
    cmd_valid_d = (state_d == StReqY) || (state_d == StReqX);
    chan_d      = ((state_d == StReqX) || (state_d == StWaitX)) ? ChX : ChY;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      ysum_q      <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      cmd_valid_q <= 1'b0;
      chan_q      <= ChY;
      y_avg_q     <= 12'h800;
      x_avg_q     <= 12'h800;
      fwd_q       <= 1'b0;
      back_q      <= 1'b0;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      dir_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ysum_q      <= ysum_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      cmd_valid_q <= cmd_valid_d;
      chan_q      <= chan_d;
      dir_valid_q <= (state_q == StDone);
      if (state_q == StDone) begin
        y_avg_q <= y_new;
        x_avg_q <= x_new;
        fwd_q   <= hi_flag(y_new, fwd_q);
        back_q  <= lo_flag(y_new, back_q);
        left_q  <= hi_flag(x_new, left_q);
        right_q <= lo_flag(x_new, right_q);
      end
    end
  end

  assign adc_if.cmd_valid   = cmd_valid_q;
  assign adc_if.cmd_channel = chan_q;
  assign y_avg_o            = y_avg_q;
  assign x_avg_o            = x_avg_q;
  assign move_fwd_o         = fwd_q;
  assign move_back_o        = back_q;
  assign turn_left_o        = left_q;
  assign turn_right_o       = right_q;
  assign dir_valid_o        = dir_valid_q;
  assign sample_err_o       = err_q;

endmodule

// File: tb/tb_joystick_sampler.sv
// Self-checking bench for joystick_sampler: directed scenarios plus randomized passes,
// checked against a frame-level average/hysteresis model.
module tb_joystick_sampler;
  localparam int unsigned Tmo = 16;
  localparam int unsigned Hi = 2000, Lo = 700, Hy = 100;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic new_frame = 1'b0;
  logic [11:0] y_avg, x_avg;
  logic fwd, back, left, right, dir_valid, sample_err;

  joystick_sampler_if bus ();

  joystick_sampler #(.TIMEOUT(Tmo)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .new_frame_i  (new_frame),
    .adc_if       (bus),
    .y_avg_o      (y_avg),
    .x_avg_o      (x_avg),
    .move_fwd_o   (fwd),
    .move_back_o  (back),
    .turn_left_o  (left),
    .turn_right_o (right),
    .dir_valid_o  (dir_valid),
    .sample_err_o (sample_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int dv_cnt = 0;
  int first_stall = 0;
  logic [11:0] smp [8];
  // Reference state
  int m_y = 2048, m_x = 2048;
  bit m_fwd = 0, m_back = 0, m_left = 0, m_right = 0, m_err = 0;

  always @(posedge clk) if (dir_valid === 1'b1) dv_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit hyst_hi(int a, bit prev);
    if (a > Hi) return 1'b1;
    if (a < Hi - Hy) return 1'b0;
    return prev;
  endfunction

  function automatic bit hyst_lo(int a, bit prev);
    if (a < Lo) return 1'b1;
    if (a > Lo + Hy) return 1'b0;
    return prev;
  endfunction

  function automatic void model_frame();
    int ys = 0, xs = 0;
    for (int i = 0; i < 4; i++) begin
      ys += smp[i];
      xs += smp[i+4];
    end
    m_y = ys / 4;
    m_x = xs / 4;
    m_fwd = hyst_hi(m_y, m_fwd);
    m_back = hyst_lo(m_y, m_back);
    m_left = hyst_hi(m_x, m_left);
    m_right = hyst_lo(m_x, m_right);
    m_err = 0;
  endfunction

  task automatic chk_outputs(input string tag);
    chk({tag, "_y"}, y_avg, m_y);
    chk({tag, "_x"}, x_avg, m_x);
    chk({tag, "_flags"}, {fwd, back, left, right}, {m_fwd, m_back, m_left, m_right});
    chk({tag, "_err"}, sample_err, m_err);
  endtask

  task automatic handshake(input logic [4:0] ch, input int stall);
    int n = 0;
    bit decoy = 1'($urandom_range(0, 1));
    while (bus.cmd_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_valid_seen", bus.cmd_valid, 1);
    chk("cmd_channel", bus.cmd_channel, ch);
    repeat (stall) @(negedge clk);
    if (stall > 0) chk("stall_cmd_held", {bus.cmd_valid, bus.cmd_channel}, {1'b1, ch});
    bus.cmd_ready = 1'b1;
    if (decoy) begin
      // Correct-channel response during the handshake cycle must not count.
      bus.rsp_valid = 1'b1;
      bus.rsp_channel = ch;
      bus.rsp_data = 12'hfff;
    end
    @(negedge clk);
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    chk("cmd_valid_drop", bus.cmd_valid, 0);
  endtask

  task automatic respond(input logic [4:0] ch, input logic [11:0] d);
    if ($urandom_range(0, 1) == 1) begin
      bus.rsp_valid = 1'b1;
      bus.rsp_channel = (ch == 5'd1) ? 5'd2 : 5'd1;
      bus.rsp_data = 12'($urandom_range(0, 4095));
      @(negedge clk);
    end
    bus.rsp_valid = 1'b1;
    bus.rsp_channel = ch;
    bus.rsp_data = d;
    @(negedge clk);
    bus.rsp_valid = 1'b0;
  endtask

  // mode 0: normal, 1: new_frame pulsed mid-pass, 2: timeout after 3rd Y handshake,
  // 3: reset during WAIT_X
  task automatic run_pass(input int mode);
    int base = dv_cnt;
    int n = 0;
    logic [4:0] ch;
    chk("pre_err", sample_err, m_err);
    new_frame = 1'b1;
    @(negedge clk);
    new_frame = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ch = (i < 4) ? 5'd1 : 5'd2;
      if (mode == 1 && i == 5) begin
        new_frame = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
      end
      handshake(ch, (i == 0) ? first_stall : $urandom_range(0, 2));
      if (mode == 2 && i == 2) begin
        while (sample_err !== 1'b1 && n < 40) begin
          @(negedge clk);
          n++;
        end
        chk("tmo_cycles", n, Tmo);
        m_err = 1;
        chk_outputs("tmo");
        repeat (3) @(negedge clk);
        chk("tmo_idle", bus.cmd_valid, 0);
        chk("tmo_no_dv", dv_cnt, base);
        return;
      end
      if (mode == 3 && i == 5) begin
        #1 reset_n = 1'b0;
        #1;
        m_y = 12'h800;
        m_x = 12'h800;
        {m_fwd, m_back, m_left, m_right, m_err} = '0;
        chk("rst_cmd_valid", bus.cmd_valid, 0);
        chk_outputs("rst");
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      respond(ch, smp[i]);
    end
    model_frame();
    while (dir_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("dv_seen", dir_valid, 1);
    chk_outputs("pass");
    @(negedge clk);
    chk("dv_one_cycle", dir_valid, 0);
    if (mode == 1) repeat (6) @(negedge clk);
    chk("dv_count", dv_cnt, base + 1);
    chk("idle_after", bus.cmd_valid, 0);
  endtask

  task automatic set_axes(input int yv, input int xv);
    for (int i = 0; i < 4; i++) begin
      smp[i] = 12'(yv);
      smp[i+4] = 12'(xv);
    end
  endtask

  function automatic int pick_base();
    case ($urandom_range(0, 3))
      0: return int'($urandom_range(1850, 2050));
      1: return int'($urandom_range(650, 850));
      default: return int'($urandom_range(0, 4095));
    endcase
  endfunction

  initial begin
    int yb, xb;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_channel = '0;
    bus.rsp_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd", {bus.cmd_valid, bus.cmd_channel}, {1'b0, 5'd1});
    chk("rst_dv", dir_valid, 0);
    m_y = 12'h800;
    m_x = 12'h800;
    chk_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    set_axes(2100, 2048);
    run_pass(0);
    foreach (smp[i]) if (i < 0) smp[i] = 0;
    set_axes(1950, 2048); run_pass(0);
    set_axes(1899, 2048); run_pass(0);
    set_axes(650, 2048);  run_pass(0);
    set_axes(790, 2048);  run_pass(0);
    set_axes(801, 2048);  run_pass(0);

    set_axes(2048, 0);
    smp[5] = 12'd1;
    smp[6] = 12'd2;
    smp[7] = 12'd4;
    run_pass(0);
    set_axes(2048, 4095); run_pass(0);

    first_stall = 10;
    set_axes(1000, 3000); run_pass(0);
    first_stall = 0;

    set_axes(100, 100); run_pass(2);
    set_axes(2500, 500); run_pass(0);

    set_axes(3000, 3000); run_pass(3);
    @(negedge clk);
    set_axes(2222, 333); run_pass(1);

    for (int p = 0; p < 20; p++) begin
      yb = pick_base();
      xb = pick_base();
      for (int i = 0; i < 4; i++) begin
        smp[i] = 12'(yb + int'($urandom_range(0, 40)) > 4095 ? 4095
                      : yb + int'($urandom_range(0, 40)));
        smp[i+4] = 12'(xb + int'($urandom_range(0, 40)) > 4095 ? 4095
                        : xb + int'($urandom_range(0, 40)));
      end
      first_stall = int'($urandom_range(0, 4));
      run_pass(int'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "bench time limit");
  end
endmodule
